// File: rtl/branch_resolve_stage.sv
// ---------------------------------------------------------------------------
// branch_resolve_stage
//
// Instruction-decode stage of the 5-stage CPU, focused on control flow.
// Holds the IF/ID pipeline register. Picks forwarded branch operands using
// the ForwardBr1/ForwardBr2 selects. Resolves branches and jumps in ID and
// drives the fetch redirect. Detects the load-use case that forwarding cannot
// cover and stalls for it. Keeps a saturating count of taken redirects.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   if_valid/if_instr/       instruction presented by fetch
//   if_pc_plus1
//   stall_in                 external hold; freezes IF/ID
//   ForwardBr1/ForwardBr2    operand selects (0 rf, 1 EX, 2 EX/MEM, 3 MEM/WB)
//   rf_data1/rf_data2        register file read data for rs / rt
//   ex_/mem_/wb_fwd_data     forwarded values
//   EX_rd_wire, RegWrite_EX,
//   MemRead_EX               destination and control of the instruction in EX
//   ID_rs, ID_rt             register fields of the instruction in ID
//   id_instr/id_pc_plus1/
//   id_valid                 IF/ID register contents
//   id_bubble                insert a NOP into ID/EX this cycle
//   fetch_hold               PC and fetch must not advance
//   redirect/redirect_pc     taken branch/jump and its target
//   taken_count              saturating count of redirect cycles
//
// Transfer semantics: if_valid qualifies if_instr/if_pc_plus1 in the cycle
// it is high. There is no ready signal. Fetch must hold its PC whenever
// fetch_hold=1. A fetched instruction is captured on the edge that ends a
// cycle with fetch_hold=0 and redirect=0. On a redirect it is discarded.
// ---------------------------------------------------------------------------
module branch_resolve_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc_plus1,
    input  logic        stall_in,
    input  logic [1:0]  ForwardBr1,
    input  logic [1:0]  ForwardBr2,
    input  logic [15:0] rf_data1,
    input  logic [15:0] rf_data2,
    input  logic [15:0] ex_fwd_data,
    input  logic [15:0] mem_fwd_data,
    input  logic [15:0] wb_fwd_data,
    input  logic [1:0]  EX_rd_wire,
    input  logic        RegWrite_EX,
    input  logic        MemRead_EX,
    output logic [1:0]  ID_rs,
    output logic [1:0]  ID_rt,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc_plus1,
    output logic        id_valid,
    output logic        id_bubble,
    output logic        fetch_hold,
    output logic        redirect,
    output logic [15:0] redirect_pc,
    output logic [15:0] taken_count
);

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_RTY = 4'd15;
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;

    logic [3:0]  opcode;
    logic [5:0]  func;
    logic        is_bne, is_beq, is_bgz, is_blz;
    logic        is_branch, is_jump_imm, is_jump_reg;
    logic [15:0] op_a, op_b;
    logic        cond_true, taken;
    logic        rs_hit, rt_hit;
    logic        hazard;
    logic [15:0] branch_target;
    logic [15:0] jump_target;

    assign opcode = id_instr[15:12];
    assign func   = id_instr[5:0];
    assign ID_rs  = id_instr[11:10];
    assign ID_rt  = id_instr[9:8];

    // Decode. The control flags are only used qualified by id_valid.
    assign is_bne      = (opcode == OP_BNE);
    assign is_beq      = (opcode == OP_BEQ);
    assign is_bgz      = (opcode == OP_BGZ);
    assign is_blz      = (opcode == OP_BLZ);
    assign is_branch   = is_bne | is_beq | is_bgz | is_blz;
    assign is_jump_imm = (opcode == OP_JMP) | (opcode == OP_JAL);
    assign is_jump_reg = (opcode == OP_RTY) & ((func == FN_JPR) | (func == FN_JRL));

    // Operand selection from register file or forwarding paths.
    always_comb begin
        op_a = rf_data1;
        case (ForwardBr1)
            2'd1:    op_a = ex_fwd_data;
            2'd2:    op_a = mem_fwd_data;
            2'd3:    op_a = wb_fwd_data;
            default: op_a = rf_data1;
        endcase
    end

    always_comb begin
        op_b = rf_data2;
        case (ForwardBr2)
            2'd1:    op_b = ex_fwd_data;
            2'd2:    op_b = mem_fwd_data;
            2'd3:    op_b = wb_fwd_data;
            default: op_b = rf_data2;
        endcase
    end

    // Branch conditions. BGZ/BLZ treat operand A as two's complement.
    always_comb begin
        cond_true = 1'b0;
        if (is_bne) cond_true = (op_a != op_b);
        if (is_beq) cond_true = (op_a == op_b);
        if (is_bgz) cond_true = ($signed(op_a) > 16'sd0);
        if (is_blz) cond_true = op_a[15];
    end

    assign taken = (is_branch & cond_true) | is_jump_imm | is_jump_reg;

    // A load in EX produces its value too late for an ID-stage compare.
    // Only BNE/BEQ read rt; BGZ/BLZ/JPR/JRL depend on rs alone.
    assign rs_hit = (ID_rs == EX_rd_wire);
    assign rt_hit = (ID_rt == EX_rd_wire) & (is_bne | is_beq);
    assign hazard = id_valid & (is_branch | is_jump_reg) &
                    RegWrite_EX & MemRead_EX & (rs_hit | rt_hit);

    // The 16-bit add wraps naturally past 16'hFFFF.
    assign branch_target = id_pc_plus1 + {{8{id_instr[7]}}, id_instr[7:0]};
    assign jump_target   = {id_pc_plus1[15:12], id_instr[11:0]};

    always_comb begin
        redirect_pc = 16'h0000;
        if (is_branch)   redirect_pc = branch_target;
        if (is_jump_imm) redirect_pc = jump_target;
        if (is_jump_reg) redirect_pc = op_a;
    end

    assign redirect   = id_valid & taken & ~hazard & ~stall_in;
    assign fetch_hold = stall_in | hazard;
    assign id_bubble  = hazard | (stall_in & id_valid);

    // IF/ID register. Priority: hold, then flush on redirect, then load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid    <= 1'b0;
            id_instr    <= 16'h0000;
            id_pc_plus1 <= 16'h0000;
        end else if (stall_in || hazard) begin
            id_valid    <= id_valid;
        end else if (redirect) begin
            id_valid    <= 1'b0;
        end else begin
            id_valid    <= if_valid;
            id_instr    <= if_instr;
            id_pc_plus1 <= if_pc_plus1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_count <= 16'h0000;
        end else if (redirect && (taken_count != 16'hFFFF)) begin
            taken_count <= taken_count + 16'h0001;
        end
    end

endmodule
